// File: rtl/stack_seq.sv
// Return-address stack sequencer: pushes return addresses/flags as 16-bit words
// onto a descending data-memory stack and pops them back to the fetch buffer.
module stack_seq #(
  parameter int              W       = 16,
  parameter int              SIZE    = 20,
  parameter logic [SIZE-1:0] SP_INIT = {SIZE{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            call,
  input  logic            ret,
  input  logic            rti,
  input  logic            int_req,
  input  logic [2*W-1:0]  pc_ret,
  input  logic [3:0]      flags_in,
  input  logic [W-1:0]    rd_data,
  output logic            mem_wr,
  output logic            mem_rd,
  output logic [SIZE-1:0] mem_addr,
  output logic [W-1:0]    mem_wdata,
  output logic [1:0]      pop_l_h,
  output logic [W-1:0]    pop_data,
  output logic            flags_restore,
  output logic [3:0]      flags_out,
  output logic            jump_isr,
  output logic            jump_ret,
  output logic            int_ack,
  output logic            stall,
  output logic [SIZE-1:0] sp
);

  typedef enum logic [3:0] {
    IDLE, PUSH_F, PUSH_L, PUSH_H, ISR_GO, POP_H, POP_L, POP_F, RET_GO
  } state_t;

  state_t          state;
  logic [2*W-1:0]  pc_lat;
  logic [3:0]      flags_lat;
  logic            is_int;
  logic            is_rti;

  // is_int / is_rti remember which sequence is running so the shared
  // push and pop chains know where to exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= SP_INIT;
      pc_lat    <= '0;
      flags_lat <= '0;
      is_int    <= 1'b0;
      is_rti    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (int_req) begin
            state     <= PUSH_F;
            pc_lat    <= pc_ret;
            flags_lat <= flags_in;
            is_int    <= 1'b1;
          end else if (rti) begin
            state  <= POP_H;
            pc_lat <= pc_ret;
            is_rti <= 1'b1;
          end else if (ret) begin
            state  <= POP_H;
            pc_lat <= pc_ret;
            is_rti <= 1'b0;
          end else if (call) begin
            state  <= PUSH_L;
            pc_lat <= pc_ret;
            is_int <= 1'b0;
          end
        end
        PUSH_F: begin
          state <= PUSH_L;
          sp    <= sp - SIZE'(1);
        end
        PUSH_L: begin
          state <= PUSH_H;
          sp    <= sp - SIZE'(1);
        end
        PUSH_H: begin
          state <= is_int ? ISR_GO : IDLE;
          sp    <= sp - SIZE'(1);
        end
        ISR_GO: state <= IDLE;
        POP_H: begin
          state <= POP_L;
          sp    <= sp + SIZE'(1);
        end
        POP_L: begin
          state <= is_rti ? POP_F : RET_GO;
          sp    <= sp + SIZE'(1);
        end
        POP_F: begin
          state <= RET_GO;
          sp    <= sp + SIZE'(1);
        end
        RET_GO:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; pops address the word just above the current stack pointer.
  always_comb begin
    mem_wr        = 1'b0;
    mem_rd        = 1'b0;
    mem_wdata     = '0;
    pop_l_h       = 2'b00;
    flags_restore = 1'b0;
    jump_isr      = 1'b0;
    jump_ret      = 1'b0;
    int_ack       = 1'b0;
    case (state)
      PUSH_F: begin
        mem_wr    = 1'b1;
        mem_wdata = {{(W-4){1'b0}}, flags_lat};
      end
      PUSH_L: begin
        mem_wr    = 1'b1;
        mem_wdata = pc_lat[W-1:0];
      end
      PUSH_H: begin
        mem_wr    = 1'b1;
        mem_wdata = pc_lat[2*W-1:W];
      end
      ISR_GO: begin
        jump_isr = 1'b1;
        int_ack  = 1'b1;
      end
      POP_H: begin
        mem_rd  = 1'b1;
        pop_l_h = 2'b11;
      end
      POP_L: begin
        mem_rd  = 1'b1;
        pop_l_h = 2'b10;
      end
      POP_F: begin
        mem_rd        = 1'b1;
        flags_restore = 1'b1;
      end
      RET_GO:  jump_ret = 1'b1;
      default: ;
    endcase
  end

  assign stall     = (state != IDLE);
  assign mem_addr  = mem_rd ? (sp + SIZE'(1)) : sp;
  assign pop_data  = rd_data;
  assign flags_out = rd_data[3:0];

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed plan steps plus random call/ret/rti/int traffic,
// checked cycle by cycle against a word-stack model with its own memory image.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call = 1'b0, ret = 1'b0, rti = 1'b0, int_req = 1'b0;
  logic [31:0] pc_ret = '0;
  logic [3:0]  flags_in = '0;
  logic [15:0] rd_data;
  logic        mem_wr, mem_rd, flags_restore, jump_isr, jump_ret, int_ack, stall;
  logic [19:0] mem_addr, sp;
  logic [15:0] mem_wdata, pop_data;
  logic [1:0]  pop_l_h;
  logic [3:0]  flags_out;

  int vectors = 0;
  int errs = 0;

  logic [15:0] mem [0:(1<<20)-1] = '{default: 16'h0};
  logic [15:0] ref_mem [logic [19:0]];
  logic [19:0] msp;

  always #5 clk = ~clk;

  assign rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  stack_seq dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .rti(rti), .int_req(int_req),
    .pc_ret(pc_ret), .flags_in(flags_in), .rd_data(rd_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pop_l_h(pop_l_h), .pop_data(pop_data), .flags_restore(flags_restore),
    .flags_out(flags_out), .jump_isr(jump_isr), .jump_ret(jump_ret),
    .int_ack(int_ack), .stall(stall), .sp(sp)
  );

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_cycle(input string ph, input logic st, input logic wr, input logic rd,
                              input logic [19:0] addr, input logic [15:0] wd,
                              input logic [1:0] plh, input logic fr, input logic isr,
                              input logic jr, input logic [15:0] pd);
    chk({ph, ".stall"}, stall, st);
    chk({ph, ".mem_wr"}, mem_wr, wr);
    chk({ph, ".mem_rd"}, mem_rd, rd);
    chk({ph, ".mem_addr"}, mem_addr, addr);
    chk({ph, ".mem_wdata"}, mem_wdata, wd);
    chk({ph, ".pop_l_h"}, pop_l_h, plh);
    chk({ph, ".flags_restore"}, flags_restore, fr);
    chk({ph, ".jump_isr"}, jump_isr, isr);
    chk({ph, ".int_ack"}, int_ack, isr);
    chk({ph, ".jump_ret"}, jump_ret, jr);
    chk({ph, ".sp"}, sp, msp);
    if (rd) chk({ph, ".pop_data"}, pop_data, pd);
    if (fr) chk({ph, ".flags_out"}, flags_out, pd[3:0]);
  endtask

  task automatic expect_idle(input string ph);
    expect_cycle(ph, 0, 0, 0, msp, 16'h0, 2'b00, 0, 0, 0, 16'h0);
  endtask

  task automatic push_word(input string ph, input logic [15:0] w);
    expect_cycle(ph, 1, 1, 0, msp, w, 2'b00, 0, 0, 0, 16'h0);
    ref_mem[msp] = w;
    msp = msp - 20'd1;
    @(negedge clk);
  endtask

  // kind: 0 call, 1 ret, 2 rti, 3 int, 4 int together with call
  task automatic run_op(input int kind, input logic [31:0] pc, input logic [3:0] fl);
    logic [19:0] a;
    logic [15:0] d;
    int npop;
    pc_ret = pc;
    flags_in = fl;
    case (kind)
      0: call = 1'b1;
      1: ret = 1'b1;
      2: rti = 1'b1;
      3: int_req = 1'b1;
      default: begin int_req = 1'b1; call = 1'b1; end
    endcase
    @(negedge clk);
    call = 1'b0; ret = 1'b0; rti = 1'b0;
    pc_ret = $urandom;
    flags_in = 4'($urandom);
    if (kind == 0 || kind >= 3) begin
      if (kind >= 3) push_word("push_f", {12'h0, fl});
      push_word("push_l", pc[15:0]);
      push_word("push_h", pc[31:16]);
      if (kind >= 3) begin
        expect_cycle("isr_go", 1, 0, 0, msp, 16'h0, 2'b00, 0, 1, 0, 16'h0);
        int_req = 1'b0;
        @(negedge clk);
      end
    end else begin
      npop = (kind == 2) ? 3 : 2;
      for (int i = 0; i < npop; i++) begin
        a = msp + 20'd1;
        d = ref_rd(a);
        expect_cycle(i == 0 ? "pop_h" : (i == 1 ? "pop_l" : "pop_f"), 1, 0, 1, a, 16'h0,
                     i == 0 ? 2'b11 : (i == 1 ? 2'b10 : 2'b00), i == 2, 0, 0, d);
        msp = msp + 20'd1;
        @(negedge clk);
      end
      expect_cycle("ret_go", 1, 0, 0, msp, 16'h0, 2'b00, 0, 0, 1, 16'h0);
      @(negedge clk);
    end
    expect_idle("after_op");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    msp = 20'hFFFFF;
  endtask

  initial begin
    msp = 20'hFFFFF;
    do_reset();
    expect_idle("reset");
    chk("reset.pop_data_follows", pop_data, mem[20'hFFFFF]);

    run_op(0, 32'h0001_2345, 4'h0);
    chk("call.sp", sp, 20'hFFFFD);
    chk("call.m_fffff", mem[20'hFFFFF], 16'h2345);
    chk("call.m_ffffe", mem[20'hFFFFE], 16'h0001);
    run_op(1, 32'h0, 4'h0);
    chk("ret.sp", sp, 20'hFFFFF);

    run_op(3, 32'h0000_0040, 4'b1010);
    chk("int.m_fffff", mem[20'hFFFFF], 16'h000A);
    chk("int.m_ffffe", mem[20'hFFFFE], 16'h0040);
    chk("int.m_ffffd", mem[20'hFFFFD], 16'h0000);
    run_op(2, 32'h0, 4'h0);
    chk("rti.sp", sp, 20'hFFFFF);

    run_op(4, 32'hCAFE_1234, 4'b0110);
    chk("int_call.sp", sp, 20'hFFFFC);
    run_op(2, 32'h0, 4'h0);

    // Reset landing in the middle of a push sequence.
    pc_ret = 32'hABCD_5678;
    call = 1'b1;
    @(negedge clk);
    call = 1'b0;
    push_word("rst_push_l", 16'h5678);
    expect_cycle("rst_push_h", 1, 1, 0, msp, 16'hABCD, 2'b00, 0, 0, 0, 16'h0);
    ref_mem[msp] = 16'hABCD;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    msp = 20'hFFFFF;
    expect_idle("rst_abort");
    @(negedge clk);
    expect_idle("rst_abort2");

    // Pop from the top of memory wraps to address 0, push from 1 wraps back.
    run_op(1, 32'h0, 4'h0);
    chk("wrap.sp", sp, 20'h00001);
    run_op(0, 32'h1357_9BDF, 4'h0);
    chk("wrap.m_00000", mem[20'h00000], 16'h1357);
    run_op(1, 32'h0, 4'h0);

    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 4)), $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        expect_idle("gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Return-address stack sequencer for the five-stage pipeline, the write side and pop driver of the fetch stage's two-cycle return-address buffer. It splits 32-bit return addresses (and interrupt flags) into 16-bit words and pushes them to the data-memory stack on CALL/INT. On RET/RTI it pops the words back, high word first, onto the fetch stage's pop interface, then selects the return path. It sits beside the memory stage, owns the stack pointer, and stalls fetch while a sequence runs.

## Interface
- W, 16, data-memory word width
- SIZE, 20, data-memory address width
- SP_INIT, 2**SIZE-1, stack pointer reset value
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- call  in  1  one-cycle pulse from decode, CALL accepted
- ret  in  1  one-cycle pulse, RET accepted
- rti  in  1  one-cycle pulse, RTI accepted
- int_req  in  1  level; held until int_ack
- pc_ret  in  2W  return address; latched with the request
- flags_in  in  4  CCR flags; latched with int_req
- rd_data  in  W  data-memory read data, combinational, same cycle as mem_addr
- mem_wr  out  1  data-memory write strobe
- mem_rd  out  1  data-memory read strobe
- mem_addr  out  SIZE  stack address
- mem_wdata  out  W  word to write
- pop_l_h  out  2  fetch pop control: 00 idle, 11 load high word, 10 load low word
- pop_data  out  W  word for the fetch pop buffer (= rd_data)
- flags_restore  out  1  write flags_out into CCR
- flags_out  out  4  popped flags (rd_data[3:0])
- jump_isr  out  1  fetch selects ISR address this cycle
- jump_ret  out  1  fetch selects buffered return address this cycle
- int_ack  out  1  one-cycle acknowledge of int_req
- stall  out  1  high = fetch PC enable forced low
- sp  out  SIZE  current stack pointer

## Operation
- Stack grows down. Push: write M[sp], then sp <= sp-1. Pop: read M[sp+1], then sp <= sp+1. All sp arithmetic is modulo 2^SIZE; overflow and underflow wrap silently.
- FSM states: IDLE, PUSH_F, PUSH_L, PUSH_H, ISR_GO, POP_H, POP_L, POP_F, RET_GO.
- In IDLE, requests are sampled. Priority is int_req > rti > ret > call. pc_ret and flags_in are latched on acceptance. Requests arriving outside IDLE are ignored; upstream keeps call/ret/rti out while stall=1, and int_req stays held.
- CALL sequence: PUSH_L (wdata=pc_ret[15:0]), then PUSH_H (wdata=pc_ret[31:16]), then IDLE.
- INT sequence: PUSH_F (wdata={12'b0, flags}), PUSH_L, PUSH_H, then ISR_GO (jump_isr=1, int_ack=1), then IDLE.
- RET sequence: POP_H (pop_l_h=11), POP_L (pop_l_h=10), then RET_GO (jump_ret=1), then IDLE.
- RTI sequence: POP_H, POP_L, POP_F (flags_restore=1), RET_GO, then IDLE.
- mem_wr=1 only in PUSH_* states, with mem_addr=sp. mem_rd=1 only in POP_* states, with mem_addr=sp+1.
- stall = (state != IDLE). All other outputs are Moore-decoded from state, sp and rd_data; they are 0 where not listed.

## Timing
- Reset values: state=IDLE, sp=SP_INIT, latches=0. Every output is 0 except sp and mem_addr (both SP_INIT) and pop_data/flags_out (which follow rd_data).
- A request accepted at edge N makes the first sequence state active in cycle N+1.
- Busy (stall) durations: CALL 2 cycles, RET 3, RTI 4, INT 4.
- Memory accesses are single-cycle; there are no wait states.
- sp updates on the edge that ends each PUSH_* or POP_* state.
- High word is always presented to fetch before low word, so fetch has the full 32-bit address by RET_GO.
- rst asserted in any state returns the FSM to IDLE at the next edge and restores sp=SP_INIT. The partial sequence is abandoned: no further writes, and no jump_* or int_ack.
- If int_req is present in the same cycle as call/ret/rti, the interrupt wins; the losing pulse is dropped, and decode must replay it.

## Test plan
- Reset, then CALL with pc_ret=0x0001_2345 -> writes M[0xFFFFF]=0x2345 and M[0xFFFFE]=0x0001; sp=0xFFFFD; stall high exactly 2 cycles.
- CALL as above, then RET with the same memory contents -> pop_l_h=11 with pop_data=0x0001, then 10 with 0x2345, then jump_ret=1 for one cycle; sp returns to 0xFFFFF.
- int_req with flags=4'b1010 and pc_ret=0x0000_0040 -> writes 0x000A, 0x0040, 0x0000 in that order; then ISR_GO with jump_isr=int_ack=1; 4 stall cycles.
- RTI after that interrupt -> pops 0x0000, 0x0040, then flags_restore=1 with flags_out=1010; then jump_ret; sp=0xFFFFF.
- int_req and call in the same cycle -> INT sequence only; no CALL writes.
- rst asserted during PUSH_H -> IDLE next cycle, sp=0xFFFFF, mem_wr=0. Also: pop at sp=0xFFFFF reads M[0x00000] (wrap).
